hpdcache_plru_ctrl: RTL and testbench

HPDCACHE_PLRU_CTRL -- requirements
Module: hpdcache_plru_ctrl

---
 rtl/hpdcache_plru_ctrl_if.sv | 64 ++++++
 rtl/hpdcache_plru_ctrl.sv | 126 ++++++++++++
 tb/tb_hpdcache_plru_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpdcache_plru_ctrl_if.sv
// rtl/hpdcache_plru_ctrl_if.sv - hit-update, refill, directory, PLRU and victim signals of the PLRU controller
interface hpdcache_plru_ctrl_if #(
  parameter int SETS = 64,
  parameter int WAYS = 4,
  parameter int NREQ = 2
);
  localparam int SW = $clog2(SETS);

  logic [NREQ-1:0]      updt_valid_i;
  logic [NREQ*SW-1:0]   updt_set_i;
  logic [NREQ*WAYS-1:0] updt_way_i;
  logic [NREQ-1:0]      updt_ready_o;

  logic                 refill_valid_i;
  logic                 refill_ready_o;
  logic [SW-1:0]        refill_set_i;
  logic                 refill_updt_plru_i;

  logic                 dir_rd_o;
  logic [SW-1:0]        dir_rd_set_o;
  logic [WAYS-1:0]      dir_valid_i;

  logic                 plru_updt_o;
  logic [SW-1:0]        plru_updt_set_o;
  logic [WAYS-1:0]      plru_updt_way_o;
  logic                 plru_repl_o;
  logic [SW-1:0]        plru_repl_set_o;
  logic [WAYS-1:0]      plru_repl_dir_valid_o;
  logic                 plru_repl_updt_o;
  logic [WAYS-1:0]      plru_victim_way_i;

  logic                 victim_valid_o;
  logic [SW-1:0]        victim_set_o;
  logic [WAYS-1:0]      victim_way_o;
  logic                 victim_ready_i;

  modport slave (
    input  updt_valid_i, updt_set_i, updt_way_i,
    output updt_ready_o,
    input  refill_valid_i, refill_set_i, refill_updt_plru_i,
    output refill_ready_o,
    output dir_rd_o, dir_rd_set_o,
    input  dir_valid_i,
    output plru_updt_o, plru_updt_set_o, plru_updt_way_o,
    output plru_repl_o, plru_repl_set_o, plru_repl_dir_valid_o, plru_repl_updt_o,
    input  plru_victim_way_i,
    output victim_valid_o, victim_set_o, victim_way_o,
    input  victim_ready_i
  );

  modport master (
    output updt_valid_i, updt_set_i, updt_way_i,
    input  updt_ready_o,
    output refill_valid_i, refill_set_i, refill_updt_plru_i,
    input  refill_ready_o,
    input  dir_rd_o, dir_rd_set_o,
    output dir_valid_i,
    input  plru_updt_o, plru_updt_set_o, plru_updt_way_o,
    input  plru_repl_o, plru_repl_set_o, plru_repl_dir_valid_o, plru_repl_updt_o,
    output plru_victim_way_i,
    input  victim_valid_o, victim_set_o, victim_way_o,
    output victim_ready_i
  );
endinterface

// File: rtl/hpdcache_plru_ctrl.sv
// rtl/hpdcache_plru_ctrl.sv - PLRU controller: round-robin hit-update arbitration and refill victim selection
module hpdcache_plru_ctrl #(
  parameter int SETS = 64,
  parameter int WAYS = 4,
  parameter int NREQ = 2
) (
  input logic                clk_i,
  input logic                rst_ni,
  hpdcache_plru_ctrl_if.slave bus
);
  localparam int SW  = $clog2(SETS);
  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, DIR, REPL, RESP} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   set_q;
  logic            updt_q;
  logic [WAYS-1:0] dirv_q;
  logic [WAYS-1:0] victim_q;
  logic [RRW-1:0]  rr_q, rr_d;
  logic            accept;
  logic            gnt_any;
  logic [RRW-1:0]  gnt_idx;
  logic [RRW-1:0]  cand;

  // Ready outputs are gated by rst_ni so nothing is granted while reset is held.
  assign accept = (state_q == IDLE) && rst_ni && bus.refill_valid_i;

  always_comb begin : fsm
    state_d                   = state_q;
    bus.refill_ready_o        = 1'b0;
    bus.dir_rd_o              = 1'b0;
    bus.dir_rd_set_o          = '0;
    bus.plru_repl_o           = 1'b0;
    bus.plru_repl_set_o       = '0;
    bus.plru_repl_dir_valid_o = '0;
    bus.plru_repl_updt_o      = 1'b0;
    bus.victim_valid_o        = 1'b0;
    case (state_q)
      IDLE: begin
        bus.refill_ready_o = rst_ni;
        if (accept) begin
          bus.dir_rd_o     = 1'b1;
          bus.dir_rd_set_o = bus.refill_set_i;
          state_d          = DIR;
        end
      end
      DIR:  state_d = REPL;
      REPL: begin
        bus.plru_repl_o           = 1'b1;
        bus.plru_repl_set_o       = set_q;
        bus.plru_repl_dir_valid_o = dirv_q;
        bus.plru_repl_updt_o      = updt_q;
        state_d                   = RESP;
      end
      RESP: begin
        bus.victim_valid_o = 1'b1;
        if (bus.victim_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.victim_set_o = set_q;
  assign bus.victim_way_o = victim_q;

  // First asserted requester at or after the pointer wins; REPL owns the PLRU port.
  always_comb begin : arbiter
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (rst_ni && (state_q != REPL)) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = RRW'((int'(rr_q) + k) % NREQ);
        if (!gnt_any && bus.updt_valid_i[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  always_comb begin : updt_out
    bus.updt_ready_o    = '0;
    bus.plru_updt_o     = 1'b0;
    bus.plru_updt_set_o = '0;
    bus.plru_updt_way_o = '0;
    rr_d                = rr_q;
    if (gnt_any) begin
      bus.updt_ready_o[gnt_idx] = 1'b1;
      bus.plru_updt_o           = 1'b1;
      bus.plru_updt_set_o       = bus.updt_set_i[int'(gnt_idx)*SW +: SW];
      bus.plru_updt_way_o       = bus.updt_way_i[int'(gnt_idx)*WAYS +: WAYS];
      rr_d                      = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + RRW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      set_q    <= '0;
      updt_q   <= 1'b0;
      dirv_q   <= '0;
      victim_q <= '0;
      rr_q     <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (accept) begin
        set_q  <= bus.refill_set_i;
        updt_q <= bus.refill_updt_plru_i;
      end
      if (state_q == DIR)  dirv_q   <= bus.dir_valid_i;
      if (state_q == REPL) victim_q <= bus.plru_victim_way_i;
    end
  end

`ifndef SYNTHESIS
  // A non-one-hot way is a requester bug; it is forwarded untouched but flagged here.
  for (genvar r = 0; r < NREQ; r++) begin : g_onehot_chk
    a_updt_way_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
      bus.updt_valid_i[r] |-> $onehot(bus.updt_way_i[r*WAYS +: WAYS]));
  end
`endif
endmodule

// File: tb/tb_hpdcache_plru_ctrl.sv
// tb/tb_hpdcache_plru_ctrl.sv - scoreboard bench for hpdcache_plru_ctrl with an LRU-list PLRU model
module tb_hpdcache_plru_ctrl;
  localparam int SETS = 64;
  localparam int WAYS = 4;
  localparam int NREQ = 2;
  localparam int SW   = $clog2(SETS);

  typedef struct packed {
    logic            refill_ready;
    logic            dir_rd;
    logic [SW-1:0]   dir_rd_set;
    logic [NREQ-1:0] updt_ready;
    logic            plru_updt;
    logic [SW-1:0]   updt_set;
    logic [WAYS-1:0] updt_way;
    logic            repl;
    logic            victim_valid;
  } cyc_t;
  typedef struct packed {
    logic [SW-1:0]   set;
    logic [WAYS-1:0] dirv;
    logic            updt;
  } repl_t;
  typedef struct packed {
    logic [SW-1:0]   set;
    logic [WAYS-1:0] way;
  } vic_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  hpdcache_plru_ctrl_if #(.SETS(SETS), .WAYS(WAYS), .NREQ(NREQ)) bus ();
  hpdcache_plru_ctrl #(.SETS(SETS), .WAYS(WAYS), .NREQ(NREQ)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  cyc_t  cyc_q[$];
  repl_t repl_q[$];
  vic_t  vic_q[$];

  // Reference: per-set LRU list (index 0 = least recent), invalid ways chosen first.
  int              lru_order [SETS][WAYS];
  logic [WAYS-1:0] dirv_mem  [SETS];
  int              pend_s[$];
  int              pend_w[$];
  bit              m_busy;
  int              m_cnt;
  logic [SW-1:0]   m_set;
  logic            m_updt;
  int              m_rr;
  logic [WAYS-1:0] last_vic_way;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int way_idx(input logic [WAYS-1:0] oh);
    for (int w = 0; w < WAYS; w++) if (oh[w]) return w;
    return 0;
  endfunction

  task automatic touch(input int s, input int w);
    int pos = 0;
    for (int p = 0; p < WAYS; p++) if (lru_order[s][p] == w) pos = p;
    for (int p = pos; p < WAYS - 1; p++) lru_order[s][p] = lru_order[s][p+1];
    lru_order[s][WAYS-1] = w;
  endtask

  function automatic logic [WAYS-1:0] victim_of(input int s, input logic [WAYS-1:0] dv);
    logic [WAYS-1:0] one = 1;
    for (int w = 0; w < WAYS; w++) if (!dv[w]) return one << w;
    return one << lru_order[s][0];
  endfunction

  task automatic step(input logic [NREQ-1:0] uv, input logic [NREQ*SW-1:0] us,
                      input logic [NREQ*WAYS-1:0] uw, input logic rv, input logic [SW-1:0] rs,
                      input logic ru, input logic vr);
    cyc_t e;
    int g, ps, pw;
    bit accept, repl_now;
    logic [WAYS-1:0] v;
    @(posedge clk_i);
    #1;
    while (pend_s.size() > 0) begin
      ps = pend_s.pop_front();
      pw = pend_w.pop_front();
      touch(ps, pw);
    end
    accept   = rv && !m_busy;
    repl_now = m_busy && (m_cnt == 2);
    bus.updt_valid_i       = uv;
    bus.updt_set_i         = us;
    bus.updt_way_i         = uw;
    bus.refill_valid_i     = rv;
    bus.refill_set_i       = rs;
    bus.refill_updt_plru_i = ru;
    bus.victim_ready_i     = vr;
    bus.dir_valid_i        = (m_busy && m_cnt == 1) ? dirv_mem[m_set] : WAYS'($urandom);
    bus.plru_victim_way_i  = WAYS'($urandom);
    e = '0;
    e.refill_ready = !m_busy;
    e.dir_rd       = accept;
    if (accept) e.dir_rd_set = rs;
    e.repl         = repl_now;
    e.victim_valid = m_busy && (m_cnt >= 3);
    g = -1;
    if (!repl_now)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && uv[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
    if (g >= 0) begin
      e.updt_ready[g] = 1'b1;
      e.plru_updt     = 1'b1;
      e.updt_set      = us[g*SW +: SW];
      e.updt_way      = uw[g*WAYS +: WAYS];
      m_rr            = (g + 1) % NREQ;
      pend_s.push_back(int'(e.updt_set));
      pend_w.push_back(way_idx(e.updt_way));
    end
    if (repl_now) begin
      v = victim_of(int'(m_set), dirv_mem[m_set]);
      bus.plru_victim_way_i = v;
      repl_q.push_back('{m_set, dirv_mem[m_set], m_updt});
      vic_q.push_back('{m_set, v});
      if (m_updt) begin
        pend_s.push_back(int'(m_set));
        pend_w.push_back(way_idx(v));
      end
    end
    cyc_q.push_back(e);
    if (accept) begin
      m_busy = 1'b1;
      m_cnt  = 1;
      m_set  = rs;
      m_updt = ru;
    end else if (m_busy) begin
      if (m_cnt >= 3) begin
        if (vr) m_busy = 1'b0;
      end else m_cnt++;
    end
  endtask

  task automatic idle_step(input logic vr);
    step('0, '0, '0, 1'b0, '0, 1'b0, vr);
  endtask

  task automatic do_refill(input logic [SW-1:0] s, input logic u, output logic [WAYS-1:0] vic);
    step('0, '0, '0, 1'b1, s, u, 1'b1);
    repeat (3) idle_step(1'b1);
    @(negedge clk_i);
    #1;
    chk("refill_victim_valid", 32'(bus.victim_valid_o), 32'd1);
    vic = bus.victim_way_o;
  endtask

  task automatic reset_and_check();
    rst_ni             = 1'b0;
    bus.updt_valid_i   = '1;
    bus.updt_way_i     = {NREQ{WAYS'(1)}};
    bus.refill_valid_i = 1'b1;
    bus.victim_ready_i = 1'b0;
    #1;
    chk("rst_refill_ready", 32'(bus.refill_ready_o), 32'd0);
    chk("rst_updt_ready", 32'(bus.updt_ready_o), 32'd0);
    chk("rst_dir_rd", 32'({bus.dir_rd_o, bus.dir_rd_set_o}), 32'd0);
    chk("rst_plru_updt", 32'({bus.plru_updt_o, bus.plru_updt_set_o, bus.plru_updt_way_o}), 32'd0);
    chk("rst_plru_repl", 32'({bus.plru_repl_o, bus.plru_repl_set_o, bus.plru_repl_dir_valid_o,
                              bus.plru_repl_updt_o}), 32'd0);
    chk("rst_victim", 32'({bus.victim_valid_o, bus.victim_set_o, bus.victim_way_o}), 32'd0);
    cyc_q.delete();
    repl_q.delete();
    vic_q.delete();
    m_busy = 1'b0;
    m_rr   = 0;
    repeat (2) @(posedge clk_i);
    #1;
    bus.updt_valid_i       = '0;
    bus.updt_way_i         = '0;
    bus.updt_set_i         = '0;
    bus.refill_valid_i     = 1'b0;
    bus.refill_set_i       = '0;
    bus.refill_updt_plru_i = 1'b0;
    bus.dir_valid_i        = '0;
    bus.plru_victim_way_i  = '0;
    rst_ni = 1'b1;
    #1;
    chk("refill_ready_after_rst", 32'(bus.refill_ready_o), 32'd1);
  endtask

  // Monitor: one control expectation per cycle, repl/victim entries on DUT presentation.
  initial begin
    cyc_t e;
    repl_t r;
    forever begin
      @(negedge clk_i);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("refill_ready", 32'(bus.refill_ready_o), 32'(e.refill_ready));
        chk("dir_rd", 32'(bus.dir_rd_o), 32'(e.dir_rd));
        chk("dir_rd_set", 32'(bus.dir_rd_set_o), 32'(e.dir_rd_set));
        chk("updt_ready", 32'(bus.updt_ready_o), 32'(e.updt_ready));
        chk("plru_updt", 32'(bus.plru_updt_o), 32'(e.plru_updt));
        chk("plru_updt_set", 32'(bus.plru_updt_set_o), 32'(e.updt_set));
        chk("plru_updt_way", 32'(bus.plru_updt_way_o), 32'(e.updt_way));
        chk("plru_repl", 32'(bus.plru_repl_o), 32'(e.repl));
        chk("victim_valid", 32'(bus.victim_valid_o), 32'(e.victim_valid));
      end
      if (bus.plru_repl_o) begin
        if (repl_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL repl_unexpected: got plru_repl_o=1 expected 0 at %0t", $time);
        end else begin
          r = repl_q.pop_front();
          chk("repl_set", 32'(bus.plru_repl_set_o), 32'(r.set));
          chk("repl_dir_valid", 32'(bus.plru_repl_dir_valid_o), 32'(r.dirv));
          chk("repl_updt", 32'(bus.plru_repl_updt_o), 32'(r.updt));
        end
      end else begin
        chk("repl_idle_zero", 32'({bus.plru_repl_set_o, bus.plru_repl_dir_valid_o,
                                   bus.plru_repl_updt_o}), 32'd0);
      end
      if (bus.victim_valid_o) begin
        if (vic_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL victim_unexpected: got victim_valid_o=1 expected 0 at %0t", $time);
        end else begin
          chk("victim_set", 32'(bus.victim_set_o), 32'(vic_q[0].set));
          chk("victim_way", 32'(bus.victim_way_o), 32'(vic_q[0].way));
          if (bus.victim_ready_i) void'(vic_q.pop_front());
        end
        last_vic_way = bus.victim_way_o;
      end
    end
  end

  initial begin
    logic [NREQ-1:0]      uv;
    logic [NREQ*SW-1:0]   us;
    logic [NREQ*WAYS-1:0] uw;
    logic [SW-1:0]        rs, vs;
    logic [WAYS-1:0]      vw, v1, v2;
    logic                 rv;
    for (int s = 0; s < SETS; s++) begin
      dirv_mem[s] = '1;
      for (int w = 0; w < WAYS; w++) lru_order[s][w] = w;
    end
    m_busy = 1'b0;
    m_rr   = 0;
    m_cnt  = 0;
    m_set  = '0;
    m_updt = 1'b0;
    reset_and_check();

    // Two requesters held together alternate starting from requester 0.
    for (int i = 0; i < 4; i++) begin
      us = {SW'(i + 1), SW'(i)};
      uw = {WAYS'(1) << (i % WAYS), WAYS'(1) << ((i + 1) % WAYS)};
      step(2'b11, us, uw, 1'b0, '0, 1'b0, 1'b1);
      @(negedge clk_i);
      #1;
      chk("rr_alternate", 32'(bus.updt_ready_o), (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    // Single refill: only way 2 invalid, victim must be way 2 at cycle 3.
    dirv_mem[5] = 4'b1011;
    do_refill(SW'(5), 1'b1, v1);
    chk("single_refill_way", 32'(v1), 32'b0100);
    chk("single_refill_set", 32'(bus.victim_set_o), 32'd5);

    // Hit update during REPL is deferred, then victim held for five unready cycles.
    dirv_mem[7] = '1;
    step('0, '0, '0, 1'b1, SW'(7), 1'b1, 1'b0);
    idle_step(1'b0);
    step(2'b01, {SW'(0), SW'(7)}, {WAYS'(0), WAYS'(2)}, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    #1;
    chk("updt_blocked_in_repl", 32'(bus.updt_ready_o), 32'd0);
    step(2'b01, {SW'(0), SW'(7)}, {WAYS'(0), WAYS'(2)}, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    #1;
    chk("updt_after_repl", 32'(bus.updt_ready_o), 32'd1);
    vs = bus.victim_set_o;
    vw = bus.victim_way_o;
    for (int i = 0; i < 4; i++) begin
      step('0, '0, '0, 1'b1, SW'(9), 1'b0, 1'b0);
      @(negedge clk_i);
      #1;
      chk("hold_valid", 32'(bus.victim_valid_o), 32'd1);
      chk("hold_set", 32'(bus.victim_set_o), 32'(vs));
      chk("hold_way", 32'(bus.victim_way_o), 32'(vw));
      chk("hold_no_refill_ready", 32'(bus.refill_ready_o), 32'd0);
    end
    idle_step(1'b1);
    idle_step(1'b1);

    // No-PLRU-update refills to a fully valid set keep returning the same victim.
    dirv_mem[9] = '1;
    do_refill(SW'(9), 1'b0, v1);
    do_refill(SW'(9), 1'b0, v2);
    chk("same_victim_no_updt", 32'(v2), 32'(v1));

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      uv = NREQ'($urandom);
      for (int r = 0; r < NREQ; r++) begin
        us[r*SW +: SW]     = SW'($urandom_range(0, 3));
        uw[r*WAYS +: WAYS] = WAYS'(1) << $urandom_range(0, WAYS - 1);
      end
      rv = ($urandom_range(0, 2) == 0);
      rs = SW'($urandom_range(0, 3));
      if (rv && !m_busy) dirv_mem[rs] = ($urandom_range(0, 1) == 1) ? '1 : WAYS'($urandom);
      step(uv, us, uw, rv, rs, 1'($urandom), ($urandom_range(0, 2) != 0));
    end
    while (m_busy) idle_step(1'b1);

    // Reset while in DIR abandons the refill; a reissued refill completes.
    dirv_mem[3] = 4'b0111;
    step('0, '0, '0, 1'b1, SW'(3), 1'b1, 1'b1);
    idle_step(1'b1);
    @(negedge clk_i);
    #1;
    reset_and_check();
    do_refill(SW'(3), 1'b1, v1);
    chk("refill_after_rst_way", 32'(v1), 32'b1000);

    idle_step(1'b1);
    idle_step(1'b1);
    @(negedge clk_i);
    #1;
    chk("victims_drained", 32'(vic_q.size()), 32'd0);
    chk("repls_drained", 32'(repl_q.size()), 32'd0);
    chk("last_victim_seen", 32'(last_vic_way), 32'b1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
